// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded instruction in, registered EX copy, stall and bubble counters out.
// master = upstream/decode side, slave = the id_ex_stage itself.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [2:0]        id_funct3;
    logic [6:0]        id_funct7;
    logic              id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch;
    logic [1:0]        id_ALUOp;
    logic              flush;

    logic              stall;
    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [2:0]        ex_funct3;
    logic [6:0]        ex_funct7;
    logic              ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch;
    logic [1:0]        ex_ALUOp;
    logic [CNT_W-1:0]  cnt_loaduse, cnt_flush;

    modport master (
        output id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7,
               id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_ALUOp, flush,
        input  stall, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
               ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp,
               cnt_loaduse, cnt_flush
    );

    modport slave (
        input  id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7,
               id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_ALUOp, flush,
        output stall, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
               ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp,
               cnt_loaduse, cnt_flush
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with one-bubble load-use interlock, flush squash and
// wrapping bubble-cause counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
    } ex_data_t;

    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ex_ctrl_t;

    ex_data_t         data_q, data_d;
    ex_ctrl_t         ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_lu_q, cnt_fl_q;
    logic             rs2_used, haz, bubble;

    assign data_d = '{pc: bus.id_pc, rd1: bus.id_rd1, rd2: bus.id_rd2, imm: bus.id_imm,
                      rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd,
                      funct3: bus.id_funct3, funct7: bus.id_funct7};
    assign ctrl_d = '{valid: 1'b1, alusrc: bus.id_ALUSrc, memtoreg: bus.id_MemtoReg,
                      regwrite: bus.id_RegWrite, memread: bus.id_MemRead,
                      memwrite: bus.id_MemWrite, branch: bus.id_Branch, aluop: bus.id_ALUOp};

    // I-type ALU ops carry an immediate in the rs2 slot; stores and branches still read rs2.
    assign rs2_used  = !bus.id_ALUSrc || bus.id_MemWrite;
    assign haz       = bus.id_valid && ctrl_q.valid && ctrl_q.memread && (|data_q.rd) &&
                       ((data_q.rd == bus.id_rs1) || (rs2_used && (data_q.rd == bus.id_rs2)));
    assign bus.stall = haz && !bus.flush && !reset;
    assign bubble    = bus.flush || haz || !bus.id_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            ctrl_q   <= '0;
            cnt_lu_q <= '0;
            cnt_fl_q <= '0;
        end else begin
            // A bubble clears only valid/control; data fields keep their last value.
            if (bubble) begin
                ctrl_q <= '0;
            end else begin
                ctrl_q <= ctrl_d;
                data_q <= data_d;
            end
            if (bus.flush)  cnt_fl_q <= cnt_fl_q + 1'b1;
            else if (haz)   cnt_lu_q <= cnt_lu_q + 1'b1;
        end
    end

    assign bus.ex_valid    = ctrl_q.valid;
    assign bus.ex_ALUSrc   = ctrl_q.alusrc;
    assign bus.ex_MemtoReg = ctrl_q.memtoreg;
    assign bus.ex_RegWrite = ctrl_q.regwrite;
    assign bus.ex_MemRead  = ctrl_q.memread;
    assign bus.ex_MemWrite = ctrl_q.memwrite;
    assign bus.ex_Branch   = ctrl_q.branch;
    assign bus.ex_ALUOp    = ctrl_q.aluop;
    assign bus.ex_pc       = data_q.pc;
    assign bus.ex_rd1      = data_q.rd1;
    assign bus.ex_rd2      = data_q.rd2;
    assign bus.ex_imm      = data_q.imm;
    assign bus.ex_rs1      = data_q.rs1;
    assign bus.ex_rs2      = data_q.rs2;
    assign bus.ex_rd       = data_q.rd;
    assign bus.ex_funct3   = data_q.funct3;
    assign bus.ex_funct7   = data_q.funct7;
    assign bus.cnt_loaduse = cnt_lu_q;
    assign bus.cnt_flush   = cnt_fl_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/wrap/reset scenarios, then a
// randomized run, all compared every cycle against an instruction-level model.
module tb_id_ex_stage;
    typedef struct {
        logic        valid;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        alusrc, memtoreg, regwrite, memread, memwrite, branch;
        logic [1:0]  aluop;
    } op_t;

    logic clk, reset, flush;
    op_t  cur;
    int   n_chk, n_err;

    id_ex_stage_if #(.DATA_W(32), .PC_W(32), .CNT_W(4)) bus();

    id_ex_stage #(.DATA_W(32), .PC_W(32), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.id_valid    = cur.valid;
    assign bus.id_pc       = cur.pc;
    assign bus.id_rd1      = cur.rd1;
    assign bus.id_rd2      = cur.rd2;
    assign bus.id_imm      = cur.imm;
    assign bus.id_rs1      = cur.rs1;
    assign bus.id_rs2      = cur.rs2;
    assign bus.id_rd       = cur.rd;
    assign bus.id_funct3   = cur.f3;
    assign bus.id_funct7   = cur.f7;
    assign bus.id_ALUSrc   = cur.alusrc;
    assign bus.id_MemtoReg = cur.memtoreg;
    assign bus.id_RegWrite = cur.regwrite;
    assign bus.id_MemRead  = cur.memread;
    assign bus.id_MemWrite = cur.memwrite;
    assign bus.id_Branch   = cur.branch;
    assign bus.id_ALUOp    = cur.aluop;
    assign bus.flush       = flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction builders ----------------
    function automatic op_t mk_nop();
        op_t o = '{default: '0};
        return o;
    endfunction

    function automatic op_t mk_base(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        op_t o = mk_nop();
        o.valid = 1'b1;
        o.pc = $urandom; o.rd1 = $urandom; o.rd2 = $urandom; o.imm = $urandom;
        o.f3 = 3'($urandom); o.f7 = 7'($urandom);
        o.rd = rd; o.rs1 = rs1; o.rs2 = rs2;
        return o;
    endfunction

    function automatic op_t mk_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [31:0] a, input logic [31:0] b);
        op_t o = mk_base(rd, rs1, rs2);
        o.rd1 = a; o.rd2 = b; o.regwrite = 1'b1; o.aluop = 2'b10;
        return o;
    endfunction

    function automatic op_t mk_lw(input logic [4:0] rd, input logic [4:0] rs1);
        op_t o = mk_base(rd, rs1, 5'd0);
        o.alusrc = 1'b1; o.memtoreg = 1'b1; o.regwrite = 1'b1; o.memread = 1'b1;
        return o;
    endfunction

    function automatic op_t mk_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2f);
        op_t o = mk_base(rd, rs1, rs2f);
        o.alusrc = 1'b1; o.regwrite = 1'b1; o.aluop = 2'b10;
        return o;
    endfunction

    function automatic op_t mk_sw(input logic [4:0] rs1, input logic [4:0] rs2);
        op_t o = mk_base(5'($urandom_range(0, 31)), rs1, rs2);
        o.alusrc = 1'b1; o.memwrite = 1'b1;
        return o;
    endfunction

    function automatic op_t mk_rand();
        op_t o = mk_base(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        o.valid    = ($urandom_range(0, 9) != 0);
        o.alusrc   = 1'($urandom); o.memtoreg = 1'($urandom); o.regwrite = 1'($urandom);
        o.memread  = ($urandom_range(0, 2) == 0);
        o.memwrite = 1'($urandom); o.branch = 1'($urandom); o.aluop = 2'($urandom);
        return o;
    endfunction

    // ---------------- behavioural model ----------------
    // m is what the EX stage must hold; counters wrap at 16.
    op_t        m;
    logic [3:0] m_cl, m_cf;
    bit         armed;

    function automatic bit exp_haz();
        return cur.valid && m.valid && m.memread && (m.rd != 5'd0) &&
               ((m.rd == cur.rs1) || ((!cur.alusrc || cur.memwrite) && (m.rd == cur.rs2)));
    endfunction

    function automatic bit exp_stall();
        return exp_haz() && !flush && !reset;
    endfunction

    always @(posedge clk) begin : model
        bit h;
        h = exp_haz();
        if (reset) begin
            m = mk_nop(); m_cl = 4'd0; m_cf = 4'd0; armed = 1'b1;
        end else if (flush || h || !cur.valid) begin
            m.valid = 0; m.alusrc = 0; m.memtoreg = 0; m.regwrite = 0;
            m.memread = 0; m.memwrite = 0; m.branch = 0; m.aluop = 2'b00;
            if (flush)  m_cf = m_cf + 4'd1;
            else if (h) m_cl = m_cl + 4'd1;
        end else begin
            m = cur;
            m.valid = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("stall",       64'(bus.stall),       64'(exp_stall()));
            chk("ex_valid",    64'(bus.ex_valid),    64'(m.valid));
            chk("ex_ALUSrc",   64'(bus.ex_ALUSrc),   64'(m.alusrc));
            chk("ex_MemtoReg", 64'(bus.ex_MemtoReg), 64'(m.memtoreg));
            chk("ex_RegWrite", 64'(bus.ex_RegWrite), 64'(m.regwrite));
            chk("ex_MemRead",  64'(bus.ex_MemRead),  64'(m.memread));
            chk("ex_MemWrite", 64'(bus.ex_MemWrite), 64'(m.memwrite));
            chk("ex_Branch",   64'(bus.ex_Branch),   64'(m.branch));
            chk("ex_ALUOp",    64'(bus.ex_ALUOp),    64'(m.aluop));
            chk("ex_pc",       64'(bus.ex_pc),       64'(m.pc));
            chk("ex_rd1",      64'(bus.ex_rd1),      64'(m.rd1));
            chk("ex_rd2",      64'(bus.ex_rd2),      64'(m.rd2));
            chk("ex_imm",      64'(bus.ex_imm),      64'(m.imm));
            chk("ex_rs1",      64'(bus.ex_rs1),      64'(m.rs1));
            chk("ex_rs2",      64'(bus.ex_rs2),      64'(m.rs2));
            chk("ex_rd",       64'(bus.ex_rd),       64'(m.rd));
            chk("ex_funct3",   64'(bus.ex_funct3),   64'(m.f3));
            chk("ex_funct7",   64'(bus.ex_funct7),   64'(m.f7));
            chk("cnt_loaduse", 64'(bus.cnt_loaduse), 64'(m_cl));
            chk("cnt_flush",   64'(bus.cnt_flush),   64'(m_cf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit hold;
        n_chk = 0; n_err = 0; armed = 1'b0;
        m = mk_nop(); m_cl = 4'd0; m_cf = 4'd0;
        reset = 1'b1; flush = 1'b0; cur = mk_nop();
        cyc(); cyc();

        // reset state; stall forced low even with a would-be hazard pattern
        cur = mk_addi(5'd1, 5'd0, 5'd0);
        #1;
        chk("lit_rst_stall",   64'(bus.stall), 64'd0);
        chk("lit_rst_valid",   64'(bus.ex_valid), 64'd0);
        chk("lit_rst_pc",      64'(bus.ex_pc), 64'd0);
        chk("lit_rst_cnt_lu",  64'(bus.cnt_loaduse), 64'd0);
        chk("lit_rst_cnt_fl",  64'(bus.cnt_flush), 64'd0);

        // pass-through add
        reset = 1'b0;
        cur = mk_add(5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
        #1 chk("lit_add_stall", 64'(bus.stall), 64'd0);
        cyc();
        chk("lit_add_valid", 64'(bus.ex_valid), 64'd1);
        chk("lit_add_aluop", 64'(bus.ex_ALUOp), 64'd2);
        chk("lit_add_rd1",   64'(bus.ex_rd1), 64'd5);
        chk("lit_add_rd2",   64'(bus.ex_rd2), 64'd7);
        chk("lit_add_rd",    64'(bus.ex_rd), 64'd3);

        // load-use on rs1: one stall, lw, bubble, addi
        cur = mk_lw(5'd5, 5'd1);
        #1 chk("lit_lu_lw_stall", 64'(bus.stall), 64'd0);
        cyc();
        chk("lit_lu_ex_lw", 64'(bus.ex_MemRead), 64'd1);
        cur = mk_addi(5'd7, 5'd5, 5'd0);
        #1 chk("lit_lu_stall1", 64'(bus.stall), 64'd1);
        cyc();
        chk("lit_lu_bub_valid", 64'(bus.ex_valid), 64'd0);
        chk("lit_lu_bub_ctrl",  64'({bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_ALUOp}), 64'd0);
        #1 chk("lit_lu_stall2", 64'(bus.stall), 64'd0);
        cyc();
        chk("lit_lu_addi_valid", 64'(bus.ex_valid), 64'd1);
        chk("lit_lu_addi_rd",    64'(bus.ex_rd), 64'd7);
        chk("lit_lu_cnt",        64'(bus.cnt_loaduse), 64'd1);

        // rs2 gating: addi ignores rs2 field, sw uses it
        cur = mk_lw(5'd6, 5'd2);
        cyc();
        cur = mk_addi(5'd8, 5'd1, 5'd6);
        #1 chk("lit_addi_rs2_stall", 64'(bus.stall), 64'd0);
        cyc();
        cur = mk_lw(5'd6, 5'd2);
        cyc();
        cur = mk_sw(5'd1, 5'd6);
        #1 chk("lit_sw_rs2_stall", 64'(bus.stall), 64'd1);
        cyc(); cyc();
        chk("lit_sw_cnt", 64'(bus.cnt_loaduse), 64'd2);

        // x0 load and non-load producer
        cur = mk_lw(5'd0, 5'd1);
        cyc();
        cur = mk_addi(5'd9, 5'd0, 5'd0);
        #1 chk("lit_x0_stall", 64'(bus.stall), 64'd0);
        cyc();
        cur = mk_add(5'd4, 5'd1, 5'd2, 32'd1, 32'd2);
        cyc();
        cur = mk_addi(5'd9, 5'd4, 5'd0);
        #1 chk("lit_nonload_stall", 64'(bus.stall), 64'd0);
        cyc();

        // flush beats hazard, from clean counters
        reset = 1'b1; cyc(); reset = 1'b0;
        cur = mk_lw(5'd5, 5'd1);
        cyc();
        cur = mk_addi(5'd7, 5'd5, 5'd0);
        flush = 1'b1;
        #1 chk("lit_fl_stall", 64'(bus.stall), 64'd0);
        cyc();
        chk("lit_fl_valid",  64'(bus.ex_valid), 64'd0);
        chk("lit_fl_cnt_fl", 64'(bus.cnt_flush), 64'd1);
        chk("lit_fl_cnt_lu", 64'(bus.cnt_loaduse), 64'd0);

        // 15 more flushes: counter reaches 15 after 14, wraps to 0 on the 16th
        repeat (14) cyc();
        chk("lit_wrap_15", 64'(bus.cnt_flush), 64'd15);
        cyc();
        chk("lit_wrap_0", 64'(bus.cnt_flush), 64'd0);
        flush = 1'b0;

        // reset while stalled
        cur = mk_lw(5'd5, 5'd1);
        cyc();
        cur = mk_addi(5'd7, 5'd5, 5'd0);
        #1 chk("lit_rms_stall_hi", 64'(bus.stall), 64'd1);
        reset = 1'b1;
        #1 chk("lit_rms_stall_lo", 64'(bus.stall), 64'd0);
        cyc();
        chk("lit_rms_valid", 64'(bus.ex_valid), 64'd0);
        chk("lit_rms_rd1",   64'(bus.ex_rd1), 64'd0);
        chk("lit_rms_rd",    64'(bus.ex_rd), 64'd0);
        chk("lit_rms_pc",    64'(bus.ex_pc), 64'd0);
        chk("lit_rms_cnt",   64'({bus.cnt_loaduse, bus.cnt_flush}), 64'd0);
        reset = 1'b0;

        // randomized traffic; upstream holds IF/ID while stalled
        hold = 1'b0;
        repeat (800) begin
            reset = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 10);
            if (!hold) cur = mk_rand();
            #1 hold = exp_stall();
            cyc();
        end
        reset = 1'b0; flush = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage with load-use hazard detection. Sits directly downstream of the decode controller: it registers the decoded control bits (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch) together with operands and register indices for the execute stage. It inserts one bubble and asserts `stall` on a load-use dependency, and squashes the ID instruction on a taken-branch flush. Two wrapping performance counters record bubble causes.

## Interface
- `DATA_W`, default 32: operand and immediate width.
- `PC_W`, default 32: program-counter width.
- `CNT_W`, default 16: performance-counter width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_pc` in PC_W; `id_rd1`, `id_rd2`, `id_imm` in DATA_W: decode-stage PC, register-file read data and immediate.
- `id_rs1`, `id_rs2`, `id_rd` in 5: source and destination register indices.
- `id_funct3` in 3; `id_funct7` in 7: function fields passed through to ALU control.
- `id_ALUSrc`, `id_MemtoReg`, `id_RegWrite`, `id_MemRead`, `id_MemWrite`, `id_Branch` in 1 each; `id_ALUOp` in 2: controller outputs.
- `flush` in 1: taken branch resolved downstream; squash the ID instruction this cycle.
- `stall` out 1: combinational; hold PC and IF/ID this cycle.
- `ex_valid` out 1; `ex_pc`, `ex_rd1`, `ex_rd2`, `ex_imm`, `ex_rs1`, `ex_rs2`, `ex_rd`, `ex_funct3`, `ex_funct7`, and all `ex_` control bits: registered copies of the corresponding `id_` inputs, with matching widths.
- `cnt_loaduse`, `cnt_flush` out CNT_W: bubble counters.

## Operation
- Source usage:
  - rs1 is always treated as used.
  - `rs2_used = !id_ALUSrc || id_MemWrite`. This covers R-type, store and branch.
- Hazard condition (`haz`): `id_valid && ex_valid && ex_MemRead && ex_rd != 0 && (ex_rd == id_rs1 || (rs2_used && ex_rd == id_rs2))`.
- `stall = haz && !flush && !reset`.
- Register update each edge, in priority order:
  1. `reset`: every registered output clears to 0, including counters.
  2. `flush`: load a bubble; `cnt_flush` increments.
  3. `haz`: load a bubble; `cnt_loaduse` increments.
  4. `!id_valid`: load a bubble; no counter change.
  5. Otherwise: load every `id_` field into its `ex_` register and set `ex_valid = 1`.
- Bubble definition:
  - `ex_valid` and all control bits (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch) clear to 0.
  - Data and index fields (pc, rd1, rd2, imm, rs1, rs2, rd, funct3, funct7) hold their previous values.
- A bubble therefore never writes the register file or memory and never branches.
- Counters are unsigned and wrap from 2^CNT_W−1 to 0. They never saturate.
- Register x0 never causes a hazard.

## Timing
- Latency: one cycle from ID to EX.
- Load-use penalty: exactly one bubble.
  - Cycle N: `haz` is true and `stall` = 1.
  - Cycle N+1: EX holds a bubble (`ex_MemRead` = 0), so `stall` = 0 and the held instruction advances into EX at edge N+1.
- `stall` is derived from registered EX state plus ID inputs. It has no dependence on other outputs of this block, so there are no combinational loops.
- `flush` and `haz` in the same cycle: flush wins. `stall` = 0, `cnt_flush` increments and `cnt_loaduse` does not.
- Reset mid-stall: `stall` drops to 0 in the same cycle. On the next edge all outputs are 0.
- Back-to-back loads feeding each other: each dependent consumer costs one bubble. A load with no dependent consumer costs none.
- Reset values: all `ex_` outputs are 0, `ex_valid` = 0, both counters are 0, and `stall` is 0 while `reset` is high.

## Test plan
- Reset then pass-through:
  - Stimulus: deassert reset; drive an R-type add (rs1=1, rs2=2, rd=3, ALUOp=2'b10, RegWrite=1, rd1=5, rd2=7).
  - Required: next cycle `ex_valid` = 1, `ex_ALUOp` = 10, `ex_rd1` = 5, `ex_rd2` = 7, `ex_rd` = 3; `stall` = 0 throughout.
- Load-use on rs1:
  - Stimulus: lw with rd=5, followed by addi with rs1=5.
  - Required: `stall` = 1 for exactly one cycle; EX shows lw, then a bubble (all control 0), then addi; `cnt_loaduse` = 1.
- rs2 gating:
  - Stimulus: lw with rd=6, followed by addi with rs2 field = 6 (ALUSrc=1, MemWrite=0).
  - Required: `stall` = 0.
  - Stimulus: lw with rd=6, followed by sw with rs2=6.
  - Required: `stall` = 1.
- x0 and non-load:
  - Stimulus: lw with rd=0, followed by a consumer of rs1=0.
  - Required: no stall.
  - Stimulus: add with rd=4, followed by a consumer of rs1=4.
  - Required: no stall.
- Flush beats hazard:
  - Stimulus: assert `flush` in the load-use cycle.
  - Required: `stall` = 0; EX gets a bubble; `cnt_flush` = 1 and `cnt_loaduse` = 0.
- Counter wrap and reset mid-stall:
  - Stimulus: with CNT_W=4, cause 16 flushes.
  - Required: `cnt_flush` returns to 0.
  - Stimulus: assert `reset` while `stall` = 1.
  - Required: `stall` = 0 immediately; all outputs are 0 after the edge.
